// File: rtl/byte_striper.sv
// byte_striper: stripes a tagged symbol stream into LANES-wide words with PCIe
// framing (STP/SDP lane-0 alignment, PAD-to-boundary termination, EDB on over-length).
module byte_striper #(
    parameter int LANES   = 4,
    parameter int MAX_LEN = 64
) (
    input  logic               clk,
    input  logic               reset_L,
    input  logic               enb,
    input  logic               valid_in,
    input  logic [7:0]         data_in,
    input  logic               data_k,
    output logic [8*LANES-1:0] lane_data,
    output logic [LANES-1:0]   lane_k,
    output logic               lane_valid,
    output logic               in_pkt,
    output logic               err
);
    localparam int PW = $clog2(LANES);
    localparam logic [7:0] PAD = 8'hF7, STP = 8'hFB, SDP = 8'h5C, END = 8'hFD, EDB = 8'hFE;
    localparam logic [PW-1:0] LAST = PW'(LANES - 1);

    typedef enum logic {IDLE, PKT} state_t;

    state_t             st_q, st_d;
    logic [8*LANES-1:0] acc_q, acc_d, data_q, data_d;
    logic [LANES-1:0]   acck_q, acck_d, k_q, k_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [7:0]         len_q, len_d;
    logic               vld_q, vld_d, err_q, err_d;
    logic               is_start, is_end, over, force_edb, term, wk_s;
    logic [7:0]         wsym;
    logic [8*LANES-1:0] wdat, tdat, rdat;
    logic [LANES-1:0]   wkv, tk, rk;

    always_comb begin
        is_start  = data_k && (data_in == STP || data_in == SDP);
        is_end    = data_k && (data_in == END || data_in == EDB);
        over      = st_q == PKT && (({1'b0, len_q} + 9'd1) == 9'(MAX_LEN));
        force_edb = over && !is_end;
        term      = st_q == PKT && (is_end || over);
        wsym      = force_edb ? EDB : data_in;
        wk_s      = force_edb ? 1'b1 : data_k;
        wdat = acc_q;
        wkv  = acck_q;
        tdat = '0;
        tk   = '0;
        rdat = '0;
        rk   = '0;
        // w*: acc with the symbol at ptr; t*: PAD after ptr (terminate); r*: PAD from ptr (realign)
        for (int i = 0; i < LANES; i++) begin
            if (i == int'(ptr_q)) begin
                wdat[8*i +: 8] = wsym;
                wkv[i]         = wk_s;
            end
            tdat[8*i +: 8] = (i > int'(ptr_q)) ? PAD : wdat[8*i +: 8];
            tk[i]          = (i > int'(ptr_q)) ? 1'b1 : wkv[i];
            rdat[8*i +: 8] = (i >= int'(ptr_q)) ? PAD : acc_q[8*i +: 8];
            rk[i]          = (i >= int'(ptr_q)) ? 1'b1 : acck_q[i];
        end
        st_d   = st_q;
        acc_d  = acc_q;
        acck_d = acck_q;
        data_d = data_q;
        k_d    = k_q;
        ptr_d  = ptr_q;
        len_d  = len_q;
        vld_d  = 1'b0;
        err_d  = 1'b0;
        if (enb && valid_in) begin
            if (st_q == IDLE && !data_k) begin
                err_d = 1'b1;
            end else if (st_q == IDLE && is_start && ptr_q != '0) begin
                data_d       = rdat;
                k_d          = rk;
                vld_d        = 1'b1;
                acc_d[7:0]   = data_in;
                acck_d[0]    = 1'b1;
                ptr_d        = PW'(1);
            end else if (term) begin
                data_d = tdat;
                k_d    = tk;
                vld_d  = 1'b1;
                ptr_d  = '0;
                st_d   = IDLE;
                err_d  = force_edb;
            end else begin
                acc_d  = wdat;
                acck_d = wkv;
                err_d  = st_q == PKT && data_k;
                if (ptr_q == LAST) begin
                    data_d = wdat;
                    k_d    = wkv;
                    vld_d  = 1'b1;
                    ptr_d  = '0;
                end else begin
                    ptr_d = ptr_q + PW'(1);
                end
            end
            if (st_q == IDLE && is_start) begin
                len_d = '0;
                st_d  = PKT;
            end else if (st_q == PKT) begin
                len_d = len_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            st_q   <= IDLE;
            acc_q  <= '0;
            acck_q <= '0;
            data_q <= '0;
            k_q    <= '0;
            ptr_q  <= '0;
            len_q  <= '0;
            vld_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            acc_q  <= acc_d;
            acck_q <= acck_d;
            data_q <= data_d;
            k_q    <= k_d;
            ptr_q  <= ptr_d;
            len_q  <= len_d;
            vld_q  <= vld_d;
            err_q  <= err_d;
        end
    end

    assign lane_data  = data_q;
    assign lane_k     = k_q;
    assign lane_valid = vld_q;
    assign err        = err_q;
    assign in_pkt     = st_q == PKT;
endmodule

// File: tb/tb_byte_striper.sv
// tb_byte_striper: directed tests of byte_striper with LANES=4, MAX_LEN=8.
module tb_byte_striper;
    logic        clk = 1'b0;
    logic        reset_L = 1'b0;
    logic        enb = 1'b1;
    logic        valid_in = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic        data_k = 1'b0;
    logic [31:0] lane_data;
    logic [3:0]  lane_k;
    logic        lane_valid, in_pkt, err;
    int checks = 0;
    int failures = 0;

    byte_striper #(.LANES(4), .MAX_LEN(8)) dut (
        .clk(clk), .reset_L(reset_L), .enb(enb), .valid_in(valid_in),
        .data_in(data_in), .data_k(data_k), .lane_data(lane_data),
        .lane_k(lane_k), .lane_valid(lane_valid), .in_pkt(in_pkt), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic send(input logic [7:0] d, input logic k, input logic v = 1'b1, input logic e = 1'b1);
        @(negedge clk);
        data_in  = d;
        data_k   = k;
        valid_in = v;
        enb      = e;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        enb      = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (lane_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=00000000", lane_data); end
        checks++; if (lane_k !== 4'h0) begin failures++; $display("FAIL reset_k got=%b exp=0000", lane_k); end
        checks++; if ({lane_valid, in_pkt, err} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {lane_valid, in_pkt, err}); end
        @(negedge clk);
        reset_L = 1'b1;
    endtask

    task automatic test_idle_word();
        send(8'h7C, 1); send(8'h7C, 1); send(8'h7C, 1);
        checks++; if (lane_valid !== 1'b0) begin failures++; $display("FAIL idle_partial_valid got=%b exp=0", lane_valid); end
        send(8'h7C, 1);
        checks++; if ({lane_valid, lane_data} !== {1'b1, 32'h7C7C7C7C}) begin failures++; $display("FAIL idle_word got=%b/%h exp=1/7C7C7C7C", lane_valid, lane_data); end
        checks++; if ({lane_k, in_pkt} !== 5'b11110) begin failures++; $display("FAIL idle_k_inpkt got=%b/%b exp=1111/0", lane_k, in_pkt); end
        send(8'h00, 0, 0);
        checks++; if ({lane_valid, lane_data} !== {1'b0, 32'h7C7C7C7C}) begin failures++; $display("FAIL idle_hold got=%b/%h exp=0/7C7C7C7C", lane_valid, lane_data); end
    endtask

    task automatic test_realign();
        send(8'hBC, 1); send(8'hBC, 1); send(8'hFB, 1);
        checks++; if ({lane_valid, lane_data, lane_k} !== {1'b1, 32'hF7F7BCBC, 4'b1111}) begin failures++; $display("FAIL realign_word got=%b/%h/%b exp=1/F7F7BCBC/1111", lane_valid, lane_data, lane_k); end
        checks++; if ({in_pkt, err} !== 2'b10) begin failures++; $display("FAIL realign_inpkt got=%b exp=10", {in_pkt, err}); end
        send(8'h01, 0); send(8'h02, 0);
        checks++; if (lane_valid !== 1'b0) begin failures++; $display("FAIL realign_gap_valid got=%b exp=0", lane_valid); end
        send(8'h03, 0);
        checks++; if ({lane_valid, lane_data, lane_k, in_pkt} !== {1'b1, 32'h030201FB, 4'b0001, 1'b1}) begin failures++; $display("FAIL realign_next got=%b/%h/%b/%b exp=1/030201FB/0001/1", lane_valid, lane_data, lane_k, in_pkt); end
        send(8'hFD, 1);
        checks++; if ({lane_valid, lane_data, lane_k, in_pkt} !== {1'b1, 32'hF7F7F7FD, 4'b1111, 1'b0}) begin failures++; $display("FAIL end_at_slot0 got=%b/%h/%b/%b exp=1/F7F7F7FD/1111/0", lane_valid, lane_data, lane_k, in_pkt); end
    endtask

    task automatic test_end_pad();
        send(8'hFB, 1); send(8'h01, 0); send(8'h02, 0); send(8'h03, 0);
        checks++; if ({lane_valid, lane_data, lane_k} !== {1'b1, 32'h030201FB, 4'b0001}) begin failures++; $display("FAIL pkt_word1 got=%b/%h/%b exp=1/030201FB/0001", lane_valid, lane_data, lane_k); end
        send(8'h04, 0); send(8'h05, 0);
        checks++; if ({lane_valid, in_pkt} !== 2'b01) begin failures++; $display("FAIL pkt_mid got=%b exp=01", {lane_valid, in_pkt}); end
        send(8'hFD, 1);
        checks++; if ({lane_valid, lane_data, lane_k} !== {1'b1, 32'hF7FD0504, 4'b1100}) begin failures++; $display("FAIL pkt_word2 got=%b/%h/%b exp=1/F7FD0504/1100", lane_valid, lane_data, lane_k); end
        checks++; if ({in_pkt, err} !== 2'b00) begin failures++; $display("FAIL pkt_close got=%b exp=00", {in_pkt, err}); end
    endtask

    task automatic test_overlength();
        send(8'hFB, 1);
        for (int i = 1; i <= 3; i++) send(8'(i), 0);
        checks++; if ({lane_valid, lane_data} !== {1'b1, 32'h030201FB}) begin failures++; $display("FAIL ovl_word1 got=%b/%h exp=1/030201FB", lane_valid, lane_data); end
        for (int i = 4; i <= 7; i++) send(8'(i), 0);
        checks++; if ({lane_valid, lane_data, lane_k, err} !== {1'b1, 32'h07060504, 4'b0000, 1'b0}) begin failures++; $display("FAIL ovl_word2 got=%b/%h/%b/%b exp=1/07060504/0000/0", lane_valid, lane_data, lane_k, err); end
        send(8'h08, 0);
        checks++; if ({lane_valid, lane_data, lane_k} !== {1'b1, 32'hF7F7F7FE, 4'b1111}) begin failures++; $display("FAIL ovl_edb got=%b/%h/%b exp=1/F7F7F7FE/1111", lane_valid, lane_data, lane_k); end
        checks++; if ({err, in_pkt} !== 2'b10) begin failures++; $display("FAIL ovl_err got=%b exp=10", {err, in_pkt}); end
        send(8'h09, 0);
        checks++; if ({err, lane_valid, in_pkt} !== 3'b100) begin failures++; $display("FAIL ovl_idle_data got=%b exp=100", {err, lane_valid, in_pkt}); end
        send(8'h00, 0, 0);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL ovl_err_pulse got=%b exp=0", err); end
        for (int i = 0; i < 4; i++) send(8'h7C, 1);
        checks++; if ({lane_valid, lane_data} !== {1'b1, 32'h7C7C7C7C}) begin failures++; $display("FAIL ovl_no_write got=%b/%h exp=1/7C7C7C7C", lane_valid, lane_data); end
    endtask

    task automatic test_enb_sdp();
        send(8'hFB, 1); send(8'h01, 0);
        for (int i = 0; i < 3; i++) begin
            send(8'hAA, 0, 1, 0);
            checks++; if ({lane_valid, err, in_pkt} !== 3'b001) begin failures++; $display("FAIL enb_hold got=%b exp=001", {lane_valid, err, in_pkt}); end
        end
        send(8'h02, 0); send(8'h03, 0);
        checks++; if ({lane_valid, lane_data, lane_k} !== {1'b1, 32'h030201FB, 4'b0001}) begin failures++; $display("FAIL enb_word got=%b/%h/%b exp=1/030201FB/0001", lane_valid, lane_data, lane_k); end
        send(8'h5C, 1);
        checks++; if ({err, in_pkt, lane_valid} !== 3'b110) begin failures++; $display("FAIL sdp_in_pkt got=%b exp=110", {err, in_pkt, lane_valid}); end
        send(8'h06, 0); send(8'hFD, 1);
        checks++; if ({lane_valid, lane_data, lane_k, in_pkt} !== {1'b1, 32'hF7FD065C, 4'b1101, 1'b0}) begin failures++; $display("FAIL sdp_word got=%b/%h/%b/%b exp=1/F7FD065C/1101/0", lane_valid, lane_data, lane_k, in_pkt); end
    endtask

    task automatic test_reset_mid();
        send(8'hFB, 1); send(8'h01, 0);
        #2 reset_L = 1'b0;
        #1;
        checks++; if ({lane_data, lane_k} !== 36'h0) begin failures++; $display("FAIL rst_mid_data got=%h/%b exp=00000000/0000", lane_data, lane_k); end
        checks++; if ({lane_valid, in_pkt, err} !== 3'b000) begin failures++; $display("FAIL rst_mid_flags got=%b exp=000", {lane_valid, in_pkt, err}); end
        @(negedge clk);
        reset_L = 1'b1;
        for (int i = 0; i < 3; i++) send(8'h7C, 1);
        checks++; if (lane_valid !== 1'b0) begin failures++; $display("FAIL rst_ptr_cleared got=%b exp=0", lane_valid); end
        send(8'h7C, 1);
        checks++; if ({lane_valid, lane_data, lane_k} !== {1'b1, 32'h7C7C7C7C, 4'b1111}) begin failures++; $display("FAIL rst_after got=%b/%h/%b exp=1/7C7C7C7C/1111", lane_valid, lane_data, lane_k); end
    endtask

    initial begin
        test_reset();
        test_idle_word();
        test_realign();
        test_end_pad();
        test_overlength();
        test_enb_sdp();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/byte_striper.md
# byte_striper

Parametrised byte-to-lane striping block for the PCIe PHY transmit path. It collects a serial stream of 8-bit symbols, each tagged data or control (K), into LANES-wide words, one symbol per lane slot in round-robin order. It enforces PCIe framing:
- STP/SDP always start on lane 0.
- A packet end (END/EDB) is padded to a word boundary with PAD.
- Over-length packets are force-terminated with EDB.

It sits upstream of the per-lane scramblers and feeds them one aligned word per emission.

## Interface
- LANES, 4: number of lanes, 2..8; the slot pointer is $clog2(LANES) bits.
- MAX_LEN, 64: maximum symbols after STP/SDP, terminator included, 2..255.
- clk  input  1  rising-edge clock.
- reset_L  input  1  reset, asynchronous assert, active-low.
- enb  input  1  block enable; when 0 the block is frozen.
- valid_in  input  1  data_in/data_k carry a symbol this cycle.
- data_in  input  8  symbol byte.
- data_k  input  1  1 = control symbol.
- lane_data  output  8*LANES  emitted word; slot i is bits [8i+7:8i].
- lane_k  output  LANES  K flag per slot.
- lane_valid  output  1  one-cycle pulse: lane_data/lane_k hold a new word.
- in_pkt  output  1  packet open (state PKT).
- err  output  1  one-cycle pulse on a framing error.

Symbol codes: COM=BC, PAD=F7, SKP=1C, STP=FB, SDP=5C, END=FD, EDB=FE, FTS=3C, IDL=7C.

## Operation
- Storage:
  - Accumulation registers acc/acc_k: LANES slots.
  - Slot pointer ptr: 0..LANES-1.
  - Output registers lane_data/lane_k.
  - Length counter len: 8 bits.
- FSM has two states, IDLE and PKT. in_pkt = (state==PKT).
- Accept condition is enb=1 and valid_in=1. Cycles that are not accepted leave all state unchanged.
- Normal write: the symbol is written to slot ptr and ptr increments.
  - When ptr==LANES-1, the word is completed instead: lane_data <= acc with the new symbol in slot LANES-1, lane_valid pulses, and ptr <= 0.
- IDLE, K symbol other than STP/SDP (COM, SKP, IDL, FTS, PAD, END, EDB): normal write.
- IDLE, data symbol (data_k=0): the symbol is dropped, err pulses, ptr is unchanged.
- IDLE, STP or SDP with data_k=1:
  - ptr==0: normal write.
  - ptr!=0: in the same cycle, emit acc with slots ptr..LANES-1 filled with PAD (k=1) and pulse lane_valid. Then acc slot 0 <= STP/SDP and ptr <= 1.
  - In both cases: len <= 0 and state <= PKT.
- PKT, every accepted symbol increments len.
- PKT, END or EDB (k=1): write to slot ptr and fill slots ptr+1..LANES-1 with PAD. Emit the word, set ptr <= 0, state <= IDLE.
- PKT, STP/SDP (k=1): err pulses and the symbol is written as a normal symbol; the packet stays open.
- PKT, other K symbols: err pulses and the symbol is written normally.
- PKT, len+1==MAX_LEN on a symbol that is not END/EDB:
  - The symbol is replaced by EDB (k=1) and terminated as an END/EDB would be.
  - err pulses and state <= IDLE.
- One emission per cycle maximum. The STP-realign case is the only one that loads acc and emits in the same cycle.
- enb=0: no writes, no emission; lane_valid=0 and err=0; all registers hold.
- Reset, including mid-packet, clears everything:
  - lane_data=0, lane_k=0, lane_valid=0, err=0, in_pkt=0.
  - ptr=0, len=0, acc=0, state=IDLE.
  - A partial word is discarded and no terminator is generated.

## Timing
- All outputs are registered.
- An accepted symbol that completes or terminates a word at edge t appears on lane_data with lane_valid=1 after edge t, for one cycle.
- lane_data/lane_k hold their value until the next emission.
- err is registered in the same edge as the offending accept and lasts one cycle.
- in_pkt rises after the STP/SDP edge and falls after the terminating edge.
- Throughput: one symbol per cycle, no back-pressure, no stall in any case, including the STP realign.
- With LANES=4 the minimum packet STP,x,END yields exactly one word.

## Test plan
- LANES=4, IDL x4 with k=1 -> one pulse: lane_data=7C7C7C7C, lane_k=1111, in_pkt=0.
- COM, COM, then STP (all k=1) -> on the STP edge, word F7F7BCBC with lane_k=1111. Then 01, 02, 03 (k=0) -> next word 030201FB with lane_k=0001, in_pkt=1.
- STP,01,02,03,04,05,END -> words 030201FB/0001, then F7FD0504/1100; in_pkt falls with the second word.
- MAX_LEN=8: STP, then data 01..09 -> words 030201FB, then 07060504, then F7F7F7FE with lane_k=1111. err pulses on the 8th symbol and 09 arrives in IDLE, giving a second err pulse and no write.
- Mid-word enb=0 for 3 cycles: ptr and acc hold, no lane_valid. SDP inside a packet -> err pulse, in_pkt stays 1.
- reset_L low mid-packet with ptr=2 -> all outputs 0 asynchronously. After release, 4 IDL symbols produce 7C7C7C7C with no stale bytes.
